// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word width, opcode encoding and the memory-stage FSM states.
package cpu_types_pkg;

    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] word_t;

    // MIPS-style primary opcodes; LL and SC are the link/conditional pair
    typedef enum logic [5:0] {
        RTYPE = 6'b000000,
        ADDIU = 6'b001001,
        LW    = 6'b100011,
        SW    = 6'b101011,
        LL    = 6'b110000,
        SC    = 6'b111000
    } opcode_t;

    // Memory stage sequencing: idle, waiting on the cache, holding load data
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } mstate_t;

endpackage

// File: rtl/memory_stage_llsc_link.sv
// Link register for LL/SC: remembers the address of the last completed LL
// and reports whether an SC address still matches a valid link.
// Only instantiated by memory_stage when LLSC_EN is defined.
module llsc_link
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    input  logic              i_ll_done,
    input  logic              i_store_done,
    input  logic              i_link_inv,
    input  logic [WORD_W-1:0] i_addr,
    output logic              o_match
);

    logic              r_link_valid;
    logic [WORD_W-1:0] r_link_addr;
    logic              w_addr_hit;
    logic              w_clear;

    assign w_addr_hit = (i_addr == r_link_addr);
    assign o_match    = r_link_valid & w_addr_hit;

    // A coherence invalidate or any completed store to the linked word breaks the link
    assign w_clear = i_link_inv | (i_store_done & w_addr_hit);

    // Link register update: clearing wins over setting in the same cycle
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_link_valid <= 1'b0;
            r_link_addr  <= '0;
        end else if (w_clear) begin
            r_link_valid <= 1'b0;
        end else if (i_ll_done) begin
            r_link_valid <= 1'b1;
            r_link_addr  <= i_addr;
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Memory-access stage between the EX/MEM and MEM/WB latches.
// Issues data-cache requests, holds them until dhit, stalls upstream while
// waiting, and parks completed load data while MEM/WB is not enabled.
// Optional LL/SC link tracking is enabled by defining LLSC_EN.
module memory_stage
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              valid_MEM,
    input  logic              MemRead_MEM,
    input  logic              MemWrite_MEM,
    input  opcode_t           opcode_MEM,
    input  logic [WORD_W-1:0] alu_out_MEM,
    input  logic [WORD_W-1:0] store_data_MEM,
    input  logic              advance,
    input  logic              flush,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    input  logic              link_inv,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic [WORD_W-1:0] Output_Port_MEM
);

    mstate_t           r_state;
    mstate_t           w_next_state;
    logic [WORD_W-1:0] r_load_q;
    logic [WORD_W-1:0] w_result;
    logic              w_is_sc;
    logic              w_sc_fail;
    logic              w_ren;
    logic              w_wen;
    logic              w_req;
    logic              w_can_issue;

    // Requests are only driven outside HOLD and never during reset
    assign w_can_issue = nRST & (r_state != HOLD);
    assign w_is_sc     = valid_MEM & MemWrite_MEM & (opcode_MEM == SC);

`ifdef LLSC_EN
    logic w_link_match;
    logic w_ll_done;
    logic w_store_done;

    // SC success is decided at issue; once a write is in flight it is never dropped
    assign w_sc_fail    = w_is_sc & (r_state == IDLE) & ~w_link_match;
    assign w_ll_done    = w_ren & dhit & (opcode_MEM == LL);
    assign w_store_done = w_wen & dhit;

    llsc_link #(
        .WORD_W (WORD_W)
    ) u_llsc_link (
        .i_clk        (CLK),
        .i_nrst       (nRST),
        .i_ll_done    (w_ll_done),
        .i_store_done (w_store_done),
        .i_link_inv   (link_inv),
        .i_addr       (alu_out_MEM),
        .o_match      (w_link_match)
    );
`else
    logic w_unused_link_inv;

    // Without link tracking SC always writes and link invalidates are ignored
    assign w_sc_fail         = 1'b0;
    assign w_unused_link_inv = link_inv;
`endif

    assign w_ren = w_can_issue & valid_MEM & MemRead_MEM;
    assign w_wen = w_can_issue & valid_MEM & MemWrite_MEM & ~MemRead_MEM & ~w_sc_fail;
    assign w_req = w_ren | w_wen;

    assign dmemREN   = w_ren;
    assign dmemWEN   = w_wen;
    assign dmemaddr  = nRST ? alu_out_MEM : '0;
    assign dmemstore = nRST ? store_data_MEM : '0;
    assign mem_stall = w_req & ~dhit;

    // Result of the instruction in the current cycle: load data on hit, SC flag, else ALU value
    always_comb begin
        w_result = alu_out_MEM;
        if (w_ren && dhit) begin
            w_result = dmemload;
        end else if (w_is_sc) begin
            w_result = {{(WORD_W-1){1'b0}}, ~w_sc_fail};
        end
    end

    assign Output_Port_MEM = !nRST            ? '0       :
                             (r_state == HOLD) ? r_load_q : w_result;

    // Next-state logic: a completed access either retires or parks in HOLD
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, WAIT: begin
                if (w_req) begin
                    if (dhit) begin
                        w_next_state = advance ? IDLE : HOLD;
                    end else begin
                        w_next_state = WAIT;
                    end
                end
            end
            HOLD: begin
                if (advance || flush) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register and capture of the completed result when MEM/WB is not enabled
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state  <= IDLE;
            r_load_q <= '0;
        end else begin
            r_state <= w_next_state;
            if ((r_state != HOLD) && w_req && dhit && !advance) begin
                r_load_q <= w_result;
            end
        end
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
Memory-access stage between the EX/MEM latch and the MEM/WB latch. Issues data-cache read/write requests and holds them until dhit. Produces Output_Port_MEM (load data, SC flag, or ALU result) and a stall for the hazard unit. Holds captured load data while the downstream latch is not enabled.

Parameters:
WORD_W, 32, datapath/address width (matches word_t)

Ports:
CLK  in  1  clock, all state updates on rising edge
nRST  in  1  reset, synchronous, active-low
valid_MEM  in  1  MEM slot holds a real instruction (0 = bubble)
MemRead_MEM  in  1  instruction is LW/LL
MemWrite_MEM  in  1  instruction is SW/SC
opcode_MEM  in  opcode_t  opcode, used for LL/SC detection
alu_out_MEM  in  WORD_W  effective address / ALU result
store_data_MEM  in  WORD_W  rt value for stores
advance  in  1  MEM/WB latch enable this cycle (the enable input of that latch)
flush  in  1  squash the instruction held in HOLD
dhit  in  1  cache completed the current request
dmemload  in  WORD_W  cache read data, valid when dhit
link_inv  in  1  coherence invalidate of the link register
dmemREN  out  1  cache read request
dmemWEN  out  1  cache write request
dmemaddr  out  WORD_W  request address = alu_out_MEM
dmemstore  out  WORD_W  write data = store_data_MEM
mem_stall  out  1  freeze upstream stages
Output_Port_MEM  out  WORD_W  value to the MEM/WB latch

Behaviour:
- Reset is synchronous: on a CLK edge with nRST=0, state=IDLE, load_q=0, link_valid=0, link_addr=0. While nRST=0, all outputs are 0.
- mem_op = valid_MEM & (MemRead_MEM | MemWrite_MEM).
- FSM states are IDLE, WAIT and HOLD.
  - IDLE: if mem_op, drive the request combinationally in the same cycle.
    - dhit & advance -> IDLE
    - dhit & !advance -> HOLD, with load_q<=dmemload
    - !dhit -> WAIT
  - WAIT: keep the request asserted with stable addr/data. Transitions are the same as IDLE on dhit; otherwise stay in WAIT.
  - HOLD: no request is driven. Output_Port_MEM=load_q. Leave to IDLE on advance or flush.
- Request outputs: dmemREN=MemRead_MEM, dmemWEN=MemWrite_MEM (modified by SC rule). REN and WEN are never both 1.
- mem_stall = (request asserted) & !dhit. Minimum latency is 0 extra cycles (dhit in the issue cycle). Otherwise the stall lasts until the dhit cycle inclusive-exclusive: mem_stall drops in the dhit cycle.
- Output_Port_MEM:
  - load in the dhit cycle: dmemload
  - HOLD: load_q
  - SC: success flag (0/1)
  - otherwise: alu_out_MEM
- flush in IDLE or WAIT is ignored. A cache request is never abandoned; the hazard unit sees mem_stall.
- A new instruction is never issued from HOLD. HOLD always returns to IDLE first.

Optional Feature:
LLSC_EN.
- Defined:
  - LL completing with dhit sets link_valid=1 and link_addr=alu_out_MEM.
  - SC checks link_valid & link_addr==alu_out_MEM.
    - On success: WEN issued; on dhit, Output_Port_MEM=1 and link_valid<=0.
    - On failure: no request, no stall, Output_Port_MEM=0 in the same cycle.
  - An SW hitting link_addr clears link_valid on dhit. link_inv clears link_valid.
  - Priority in the same cycle: clear > set.
- Undefined: LL behaves as LW, SC behaves as SW with Output_Port_MEM=1, and link_inv is ignored.

Decomposition:
- The mstate_t enum (IDLE, WAIT, HOLD) is added to cpu_types_pkg. The LL/SC opcodes come from the existing opcode_t.
- One sub-module, llsc_link: link register, match compare and clear/set priority. It is instantiated only under LLSC_EN.

Test Plan:
1. LW addr 0x100, dhit in issue cycle, advance=1 -> REN=1 one cycle, mem_stall=0, Output_Port_MEM=dmemload=0xDEADBEEF.
2. SW addr 0x200 data 0x1234, dhit after 3 cycles -> WEN held 3 cycles with stable addr/data, mem_stall=1 for those 3 cycles, 0 on the dhit cycle.
3. LW with dhit but advance=0 for 2 cycles, dmemload changes afterwards -> HOLD, Output_Port_MEM stays at the captured 0xCAFEF00D, no re-request. flush in HOLD -> IDLE.
4. nRST=0 asserted mid-WAIT -> the next edge forces IDLE, REN/WEN=0, mem_stall=0, load_q=0.
5. LLSC_EN: LL 0x300 then SC 0x300 -> SC writes, Output=1. Repeat with link_inv between -> no WEN, Output=0, no stall.
6. ALU op (MemRead=MemWrite=0, alu_out 0x55) and bubble (valid_MEM=0) -> no request, Output_Port_MEM=0x55, mem_stall=0.
